// File: rtl/multi_debouncer_pkg.sv
// Shared constants and width helper for the multi-channel switch debouncer.
// Imported by the top level and by every debounce channel.
package multi_debouncer_pkg;

    localparam int DEFAULT_TICK_DIV     = 1000;
    localparam int DEFAULT_STABLE_TICKS = 20;
    localparam int DEFAULT_LONG_TICKS   = 500;

    // Bits needed to hold 0..maxVal; never less than one bit.
    function automatic int widthFor(input int maxVal);
        if (maxVal < 1) begin
            return 1;
        end
        return $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/multi_debouncer_channel.sv
// One debounce channel: 2-FF synchroniser, tick-based stability counter,
// registered edge pulses and an optional one-shot long-press detector.
module debounce_channel
    import multi_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS
) (
    input  logic CLK,
    input  logic RST,
    input  logic raw_i,
    input  logic tick_i,
    output logic state_o,
    output logic transUp_o,
    output logic transDn_o,
    output logic longPress_o
);

    localparam int SW = widthFor(STABLE_TICKS);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          state_q;
    logic          state_d;
    logic [SW-1:0] stableCnt_q;
    logic [SW-1:0] stableCnt_d;
    logic          transUp_q;
    logic          transUp_d;
    logic          transDn_q;
    logic          transDn_d;
    logic          flip;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Any cycle where the synchronised input agrees with the state restarts the count.
    always_comb begin
        stableCnt_d = stableCnt_q;
        state_d     = state_q;
        flip        = 1'b0;
        if (sync2_q == state_q) begin
            stableCnt_d = '0;
        end else if (tick_i) begin
            if (stableCnt_q == STABLE_LAST) begin
                flip        = 1'b1;
                state_d     = sync2_q;
                stableCnt_d = '0;
            end else begin
                stableCnt_d = stableCnt_q + 1'b1;
            end
        end
        transUp_d = flip & sync2_q;
        transDn_d = flip & ~sync2_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= 1'b0;
            stableCnt_q <= '0;
            transUp_q   <= 1'b0;
            transDn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stableCnt_q <= stableCnt_d;
            transUp_q   <= transUp_d;
            transDn_q   <= transDn_d;
        end
    end

    assign state_o   = state_q;
    assign transUp_o = transUp_q;
    assign transDn_o = transDn_q;

    generate
        if (LONG_TICKS > 0) begin : gLong
            localparam int HW = widthFor(LONG_TICKS);
            localparam logic [HW-1:0] LONG_LAST = HW'(LONG_TICKS - 1);
            localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_TICKS);

            logic [HW-1:0] holdCnt_q;
            logic [HW-1:0] holdCnt_d;
            logic          longPress_q;
            logic          longPress_d;

            // Saturation at LONG_MAX is what keeps the pulse one-shot per press;
            // a tick that also releases the switch suppresses the pulse.
            always_comb begin
                holdCnt_d   = holdCnt_q;
                longPress_d = 1'b0;
                if (!state_q) begin
                    holdCnt_d = '0;
                end else if (tick_i && (holdCnt_q != LONG_MAX)) begin
                    holdCnt_d   = holdCnt_q + 1'b1;
                    longPress_d = (holdCnt_q == LONG_LAST) && !flip;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    holdCnt_q   <= '0;
                    longPress_q <= 1'b0;
                end else begin
                    holdCnt_q   <= holdCnt_d;
                    longPress_q <= longPress_d;
                end
            end

            assign longPress_o = longPress_q;
        end else begin : gNoLong
            assign longPress_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/multi_debouncer.sv
// N-channel switch debouncer: a shared sample-tick prescaler feeding one
// debounce_channel instance per switch input.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int N_CH         = 3,
    parameter int TICK_DIV     = DEFAULT_TICK_DIV,
    parameter int STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int LONG_TICKS   = DEFAULT_LONG_TICKS
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [N_CH-1:0] switch_in,
    output logic [N_CH-1:0] state,
    output logic [N_CH-1:0] trans_up,
    output logic [N_CH-1:0] trans_dn,
    output logic [N_CH-1:0] long_press,
    output logic            tick
);

    localparam int DW = widthFor(TICK_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] divCnt_q;
    logic [DW-1:0] divCnt_d;
    logic          tick_q;
    logic          tick_d;

    // Tick is registered from the next count so it is high exactly while divCnt_q is at DIV_LAST.
    always_comb begin
        divCnt_d = (divCnt_q == DIV_LAST) ? '0 : divCnt_q + 1'b1;
        tick_d   = (divCnt_d == DIV_LAST);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            divCnt_q <= '0;
            tick_q   <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

    generate
        for (genvar ch = 0; ch < N_CH; ch++) begin : gChan
            debounce_channel #(
                .STABLE_TICKS(STABLE_TICKS),
                .LONG_TICKS  (LONG_TICKS)
            ) uChan (
                .CLK        (CLK),
                .RST        (RST),
                .raw_i      (switch_in[ch]),
                .tick_i     (tick_q),
                .state_o    (state[ch]),
                .transUp_o  (trans_up[ch]),
                .transDn_o  (trans_dn[ch]),
                .longPress_o(long_press[ch])
            );
        end
    endgenerate

endmodule
